// File: rtl/counter_scheduler_if.sv
// Request/grant bundle between client FSMs and the shared interval counter scheduler.
// master = client side, slave = scheduler side.
interface counter_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NBITS   = 8
);
  logic                       enable;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*NBITS-1:0]   length;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       busy;
  logic                       flag;
  logic [NBITS-1:0]           CountOut;

  modport master (
    output enable, req, length,
    input  grant, done, busy, flag, CountOut
  );

  modport slave (
    input  enable, req, length,
    output grant, done, busy, flag, CountOut
  );
endinterface

// File: rtl/counter_scheduler.sv
// Round-robin owner selection for one modulo interval counter; the winner's
// length is latched at grant and completion is signalled by a one-cycle done.
module counter_scheduler #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned MAXIMUM_VALUE     = 256,
  parameter int unsigned NBITS_FOR_COUNTER = $clog2(MAXIMUM_VALUE)
) (
  input  logic                clk,
  input  logic                reset,
  counter_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = NBITS_FOR_COUNTER;
  localparam logic [CNT_W-1:0] TC_MAX = CNT_W'(MAXIMUM_VALUE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   tc_q, tc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               flag_q, flag_d;

  logic [IDX_W-1:0]   pick_c;
  logic [CNT_W-1:0]   pick_len_c;
  logic [IDX_W-1:0]   owner_inc_c;
  logic [NUM_REQ-1:0] owner_onehot_c;
  int unsigned        arb_idx;

  // First requesting index at or above the pointer, wrapping to 0.
  always_comb begin
    pick_c  = ptr_q;
    arb_idx = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      arb_idx = 32'(ptr_q) + k - 1;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (bus.req[IDX_W'(arb_idx)]) pick_c = IDX_W'(arb_idx);
    end
  end

  always_comb begin
    pick_len_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_c) pick_len_c = bus.length[i*CNT_W +: CNT_W];
    end
  end

  assign owner_inc_c = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

  // Next state, latched fields and next registered outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tc_d    = tc_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick_c;
          tc_d    = (pick_len_c > TC_MAX) ? TC_MAX : pick_len_c;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Owner withdrawal beats terminal count on the same edge.
        if (!bus.req[owner_q]) begin
          count_d = '0;
          ptr_d   = owner_inc_c;
          state_d = IDLE;
        end else if (bus.enable) begin
          if (count_q == tc_q) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        ptr_d   = owner_inc_c;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    owner_onehot_c = NUM_REQ'(1) << owner_d;
    grant_d = (state_d == RUN)  ? owner_onehot_c : '0;
    done_d  = (state_d == DONE) ? owner_onehot_c : '0;
    busy_d  = (state_d == RUN);
    flag_d  = (state_d == RUN) && (count_d == tc_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      tc_q    <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      tc_q    <= tc_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.flag     = flag_q;
  assign bus.CountOut = count_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: directed scenarios plus randomized requesters,
// every cycle compared against a transaction-level reference model.
module tb_counter_scheduler;

  localparam int N    = 4;
  localparam int MAXV = 10;
  localparam int NB   = $clog2(MAXV);
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_scheduler_if #(.NUM_REQ(N), .NBITS(NB)) bus ();

  counter_scheduler #(.NUM_REQ(N), .MAXIMUM_VALUE(MAXV), .NBITS_FOR_COUNTER(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int len_arr [N];
  always_comb begin
    bus.length = '0;
    for (int i = 0; i < N; i++) bus.length[i*NB +: NB] = NB'(len_arr[i]);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the counter, how far it has counted, where the pointer is.
  int m_state, m_owner, m_ptr, m_tc, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_owner = 0; m_ptr = 0; m_tc = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    case (m_state)
      M_IDLE: begin
        if (bus.req != '0) begin
          for (int k = N - 1; k >= 0; k--)
            if (bus.req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_tc    = (len_arr[m_owner] > MAXV - 1) ? MAXV - 1 : len_arr[m_owner];
          m_cnt   = 0;
          m_state = M_RUN;
        end
      end
      M_RUN: begin
        if (!bus.req[m_owner]) begin
          m_state = M_IDLE; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end else if (bus.enable) begin
          if (m_cnt == m_tc) begin m_cnt = 0; m_state = M_DONE; end
          else m_cnt = m_cnt + 1;
        end
      end
      default: begin
        m_ptr = (m_owner + 1) % N; m_state = M_IDLE;
      end
    endcase
  endtask

  task automatic compare();
    int onehot;
    onehot = 1 << m_owner;
    check("grant", 32'(bus.grant),    (m_state == M_RUN)  ? 32'(onehot) : 32'd0);
    check("done",  32'(bus.done),     (m_state == M_DONE) ? 32'(onehot) : 32'd0);
    check("busy",  32'(bus.busy),     (m_state == M_RUN)  ? 32'd1 : 32'd0);
    check("flag",  32'(bus.flag),     (m_state == M_RUN && m_cnt == m_tc) ? 32'd1 : 32'd0);
    check("count", 32'(bus.CountOut), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // Clock one edge; the owner withdraws after its done pulse unless it chooses to re-request.
  task automatic step(input bit may_keep);
    tick();
    if (m_state == M_DONE && !(may_keep && $urandom_range(0, 3) == 0)) bus.req[m_owner] = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      step(1'b0);
      ok = (bus.req == '0 && m_state == M_IDLE);
    end
    check("drain_idle", 32'(ok), 32'd1);
  endtask

  initial begin
    int seq [5];
    int gcyc [5];
    int nseen, gcount, fcount, dseen, maxcnt;
    bit found;
    logic [N-1:0] rearm;

    reset = 1'b0;
    bus.enable = 1'b0;
    bus.req = '0;
    for (int i = 0; i < N; i++) len_arr[i] = 0;
    model_reset();
    #3 compare();
    #20 reset = 1'b1;

    // Round-robin fairness with zero-length intervals.
    bus.enable = 1'b1;
    bus.req = '1;
    rearm = '0;
    nseen = 0;
    for (int c = 0; c < 40 && nseen < 5; c++) begin
      for (int i = 0; i < N; i++) if (rearm[i]) begin bus.req[i] = 1'b1; rearm[i] = 1'b0; end
      tick();
      if (bus.grant != '0) begin
        for (int i = 0; i < N; i++) if (bus.grant[i]) seq[nseen] = i;
        gcyc[nseen] = c;
        nseen++;
      end
      if (m_state == M_DONE) begin bus.req[m_owner] = 1'b0; rearm[m_owner] = 1'b1; end
    end
    check("rr_seen", 32'(nseen), 32'd5);
    for (int k = 0; k < 5; k++) check("rr_order", 32'(seq[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) check("rr_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
    bus.req = '0;
    drain();

    // Single request of length 3.
    len_arr[0] = 3;
    bus.req = 4'b0001;
    gcount = 0; fcount = 0; dseen = 0;
    for (int c = 0; c < 20 && dseen == 0; c++) begin
      step(1'b0);
      if (bus.grant == 4'b0001) begin
        check("single_count", 32'(bus.CountOut), 32'(gcount));
        gcount++;
      end
      if (bus.flag) fcount++;
      if (bus.done == 4'b0001) dseen = 1;
    end
    check("single_grant_cycles", 32'(gcount), 32'd4);
    check("single_flag_cycles", 32'(fcount), 32'd1);
    check("single_done", 32'(dseen), 32'd1);
    drain();

    // Clamp to MAXIMUM_VALUE-1 with enable toggling.
    len_arr[1] = 15;
    bus.req = 4'b0010;
    maxcnt = 0; dseen = 0;
    for (int c = 0; c < 60 && dseen == 0; c++) begin
      bus.enable = ~bus.enable;
      step(1'b0);
      if (bus.busy && 32'(bus.CountOut) > 32'(maxcnt)) maxcnt = int'(bus.CountOut);
      if (bus.done[1]) dseen = 1;
    end
    check("clamp_max_count", 32'(maxcnt), 32'(MAXV - 1));
    check("clamp_done", 32'(dseen), 32'd1);
    bus.enable = 1'b1;
    drain();

    // Abort by owner 2; requester 3 must win over 0 next.
    len_arr[2] = 5;
    bus.req = 4'b0100;
    tick();
    check("abort_granted", 32'(bus.grant), 32'h4);
    bus.req[0] = 1'b1; bus.req[3] = 1'b1;
    tick();
    bus.req[2] = 1'b0;
    tick();
    check("abort_no_grant", 32'(bus.grant), 32'd0);
    check("abort_no_done", 32'(bus.done), 32'd0);
    tick();
    check("abort_next_owner", 32'(bus.grant), 32'h8);
    drain();

    // Withdrawal on the terminal-count edge: no done.
    len_arr[1] = 2;
    bus.req = 4'b0010;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      found = (m_state == M_RUN && m_cnt == m_tc);
    end
    check("simul_reached_tc", 32'(found), 32'd1);
    bus.req[1] = 1'b0;
    tick();
    check("simul_no_done", 32'(bus.done), 32'd0);
    tick();
    check("simul_no_done_late", 32'(bus.done), 32'd0);
    drain();

    // Asynchronous reset mid-interval.
    len_arr[0] = 9;
    bus.req = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      found = (m_state == M_RUN && m_cnt == 5);
    end
    check("rst_reached_5", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 model_reset();
    compare();
    #2 reset = 1'b1;
    tick();
    check("rst_regrant", 32'(bus.grant), 32'h1);
    check("rst_fresh_count", 32'(bus.CountOut), 32'd0);
    drain();

    // Randomized requesters, lengths and enable.
    for (int c = 0; c < 3000; c++) begin
      bus.enable = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b1;
          len_arr[i] = int'($urandom_range(0, 15));
        end else if (bus.req[i] && m_state == M_RUN && m_owner == i && $urandom_range(0, 40) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 2) == 0) len_arr[$urandom_range(0, N - 1)] = int'($urandom_range(0, 15));
      step(1'b1);
    end
    bus.req = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
